rd_rotate_buf_sdp: RTL and testbench

Simple dual-port, width-converting line buffer for the rotate read path. It accepts 256-bit words on a write port and returns them as 32-bit slices on an independent read port, 8 slices per written word, least-significant slice first. It sits between the DDR read burst stage (256-bit) and the 32-bit pixel rotation logic. Both ports share one clock.

---
 rtl/rd_rotate_buf_sdp.sv | 53 +++++
 tb/tb_rd_rotate_buf_sdp.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rd_rotate_buf_sdp.sv
// Simple dual-port line buffer: 256-bit word writes, 32-bit slice reads, one clock.
// The read port returns a registered slice of the addressed word, least-significant slice first.
module rd_rotate_buf_sdp #(
  parameter int unsigned WR_ADDR_WIDTH = 10,
  parameter int unsigned WR_DATA_WIDTH = 256,
  parameter int unsigned RD_ADDR_WIDTH = 13,
  parameter int unsigned RD_DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned SLICE_BITS = RD_ADDR_WIDTH - WR_ADDR_WIDTH;
  localparam int unsigned DEPTH      = 1 << WR_ADDR_WIDTH;

  logic [WR_DATA_WIDTH-1:0] mem [DEPTH];
  logic [WR_ADDR_WIDTH-1:0] rd_word;
  logic [RD_DATA_WIDTH-1:0] rd_slice_data;

  assign rd_word = rd_addr[RD_ADDR_WIDTH-1:SLICE_BITS];

  generate
    if (SLICE_BITS > 0) begin : g_slice
      logic [SLICE_BITS-1:0] rd_slice;
      assign rd_slice      = rd_addr[SLICE_BITS-1:0];
      assign rd_slice_data = mem[rd_word][rd_slice*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end else begin : g_noslice
      assign rd_slice_data = mem[rd_word][RD_DATA_WIDTH-1:0];
    end
  endgenerate

  // Storage is never reset; writes are simply blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking update against the old array contents gives read-before-write on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_slice_data;
    end
  end

endmodule

// File: tb/tb_rd_rotate_buf_sdp.sv
// Directed self-checking bench for rd_rotate_buf_sdp with immediate assertions.
module tb_rd_rotate_buf_sdp;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [255:0] wr_data;
  logic [12:0]  rd_addr;
  logic [31:0]  rd_data;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  rd_rotate_buf_sdp #(
    .WR_ADDR_WIDTH(10),
    .WR_DATA_WIDTH(256),
    .RD_ADDR_WIDTH(13),
    .RD_DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    checks++;
    assert (rd_data === expected) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, rd_data, expected);
    end
  endtask

  initial begin
    logic [255:0] word;

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    // Reset held for 20 cycles with random read addresses.
    for (int i = 0; i < 20; i++) begin
      rd_addr = 13'($urandom);
      step();
      check("reset_hold", 32'h0);
    end
    rst_n = 1'b1;
    #1;
    check("reset_release_pre_edge", 32'h0);

    // Fill every word: slice j of word k = k*8+j.
    wr_en = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      for (int j = 0; j < 8; j++) word[j*32 +: 32] = 32'(k*8 + j);
      wr_addr = 10'(k);
      wr_data = word;
      step();
    end
    wr_en = 1'b0;

    // Stream the whole buffer back-to-back.
    for (int a = 0; a < 8192; a++) begin
      rd_addr = 13'(a);
      step();
      check("stream", 32'(a));
    end

    // Slice order on word 5.
    for (int j = 0; j < 8; j++) word[j*32 +: 32] = 32'(j) * 32'h1111_1111;
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = word;
    step();
    wr_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      rd_addr = 13'(40 + j);
      step();
      check("slice_order", 32'(j) * 32'h1111_1111);
    end

    // Collision: read-before-write, then new data visible.
    wr_en = 1'b1; wr_addr = 10'd3; wr_data = {32{8'hAA}};
    step();
    wr_data = {32{8'h55}}; rd_addr = 13'd24;
    step();
    check("collision_old", 32'hAAAA_AAAA);
    wr_en = 1'b0;
    step();
    check("collision_new", 32'h5555_5555);

    // wr_en gating: word 7 keeps its fill contents.
    wr_en = 1'b0; wr_addr = 10'd7; wr_data = '1;
    step();
    wr_data = '0;
    for (int j = 0; j < 8; j++) begin
      rd_addr = 13'(56 + j);
      step();
      check("wr_en_gate", 32'(56 + j));
    end

    // Async reset mid-stream.
    for (int a = 100; a < 104; a++) begin
      rd_addr = 13'(a);
      step();
      check("pre_reset_stream", 32'(a));
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", 32'h0);
    for (int i = 0; i < 2; i++) begin
      rd_addr = 13'(104 + i);
      step();
      check("async_reset_hold", 32'h0);
    end
    rst_n = 1'b1;
    #1;
    check("async_release_pre_edge", 32'h0);
    for (int a = 104; a < 112; a++) begin
      rd_addr = 13'(a);
      step();
      check("post_reset_stream", 32'(a));
    end
    rd_addr = 13'd40;
    step();
    check("post_reset_word5", 32'h0);
    rd_addr = 13'd24;
    step();
    check("post_reset_word3", 32'h5555_5555);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
